// File: rtl/titan_pkg.sv
// Shared definitions for the titan core front end: bubble encoding, reset PC and fetch FSM states.
package titan_pkg;

   localparam logic [31:0] NOP_INST_ENC = 32'h0000_0033;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_FETCH,
      ST_HOLD,
      ST_DISCARD,
      ST_MISAL,
      ST_FAULT
   } fetch_state_t;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Instruction holding register: keeps a fetched word while the pipeline is stalled.
module if_hold_buf
   import titan_pkg::*;
#(
   parameter logic [31:0] RESET_VAL = NOP_INST_ENC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clr,
   input  logic [31:0] d,
   output logic [31:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      q <= RESET_VAL;
      else if (load) q <= d;
      else if (clr)  q <= RESET_VAL;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, one-outstanding imem fetch, bubble insertion, stall and redirect.
// Optional instruction-fetch bus error reporting is enabled by defining IMEM_FAULT_EN.
module if_fetch_unit
   import titan_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_ENC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
`ifdef IMEM_FAULT_EN
   input  logic        imem_err,
   output logic        if_exc_fault,
`endif
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_add4,
   output logic        if_exc_addr,
   output logic [31:0] if_inst
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_add4;
   logic [31:0]  buf_q;
   logic         ack_ok;
   logic         buf_load;
   logic         buf_clr;

   assign pc_add4 = pc + 32'd4;

`ifdef IMEM_FAULT_EN
   assign ack_ok = imem_ack & ~imem_err;
`else
   assign ack_ok = imem_ack;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_BOOT;
         pc    <= RESET_PC;
      end else if (redirect) begin
         // Redirect wins over stall; an unacked request must still be drained in DISCARD.
         pc <= redirect_pc;
         if (is_misaligned(redirect_pc))
            state <= ST_MISAL;
         else if ((state == ST_FETCH || state == ST_DISCARD) && !imem_ack)
            state <= ST_DISCARD;
         else
            state <= ST_FETCH;
      end else begin
         case (state)
            ST_BOOT: state <= ST_FETCH;
            ST_FETCH: begin
               if (imem_ack) begin
`ifdef IMEM_FAULT_EN
                  if (imem_err) state <= ST_FAULT;
                  else
`endif
                  if (stall) state <= ST_HOLD;
                  else       pc    <= pc_add4;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  pc    <= pc_add4;
                  state <= ST_FETCH;
               end
            end
            ST_DISCARD: if (imem_ack) state <= ST_FETCH;
            ST_MISAL:   state <= ST_MISAL;
            ST_FAULT:   state <= ST_FAULT;
            default:    state <= ST_BOOT;
         endcase
      end
   end

   assign buf_load = (state == ST_FETCH) & ack_ok & stall & ~redirect;
   assign buf_clr  = (state == ST_HOLD) & (~stall | redirect);

   if_hold_buf #(.RESET_VAL(NOP_INST)) u_hold_buf (
      .clk  (clk),
      .rst  (rst),
      .load (buf_load),
      .clr  (buf_clr),
      .d    (imem_rdata),
      .q    (buf_q)
   );

   // NOTE: if_inst gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      if_inst = NOP_INST;
      if (!redirect) begin
         case (state)
            ST_FETCH: if (ack_ok) if_inst = imem_rdata;
            ST_HOLD:  if_inst = buf_q;
            default:  if_inst = NOP_INST;
         endcase
      end
   end

   assign imem_req    = (state == ST_FETCH);
   assign imem_addr   = pc;
   assign if_pc       = pc;
   assign if_pc_add4  = pc_add4;
   assign if_exc_addr = (state == ST_MISAL);

`ifdef IMEM_FAULT_EN
   assign if_exc_fault = (state == ST_FAULT) |
                         ((state == ST_FETCH) & imem_ack & imem_err & ~redirect);
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit: boot, zero-wait stream, wait states, stall, redirect,
// misaligned target, PC wrap and mid-request reset.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_pc_add4;
   logic        if_exc_addr;
   logic [31:0] if_inst;
`ifdef IMEM_FAULT_EN
   logic        imem_err = 1'b0;
   logic        if_exc_fault;
`endif

   logic        ack_auto;
   logic        ack_force;
   int          checks = 0;
   int          errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0033;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign imem_ack   = ack_force | (ack_auto & imem_req);
   assign imem_rdata = mem_word(imem_addr);

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
`ifdef IMEM_FAULT_EN
      .imem_err    (imem_err),
      .if_exc_fault(if_exc_fault),
`endif
      .if_pc       (if_pc),
      .if_pc_add4  (if_pc_add4),
      .if_exc_addr (if_exc_addr),
      .if_inst     (if_inst)
   );

   task automatic test_reset();
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      ack_auto = 1'b0; ack_force = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", if_pc); end
      checks++; if (if_pc_add4 !== 32'h4) begin errors++; $display("FAIL rst_add4 got %h exp 4", if_pc_add4); end
      checks++; if (if_exc_addr !== 1'b0) begin errors++; $display("FAIL rst_exc got %b exp 0", if_exc_addr); end
      checks++; if (if_inst !== NOP) begin errors++; $display("FAIL rst_inst got %h exp %h", if_inst, NOP); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req); end
      @(negedge clk);
   endtask

   task automatic test_zero_wait();
      ack_auto = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
            errors++; $display("FAIL zw_req%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i)); end
         checks++; if (if_pc !== 32'(4 * i) || if_pc_add4 !== 32'(4 * i + 4)) begin
            errors++; $display("FAIL zw_pc%0d got %h/%h exp %h/%h", i, if_pc, if_pc_add4, 32'(4 * i), 32'(4 * i + 4)); end
         checks++; if (if_inst !== mem_word(32'(4 * i))) begin
            errors++; $display("FAIL zw_inst%0d got %h exp %h", i, if_inst, mem_word(32'(4 * i))); end
         @(negedge clk);
      end
   endtask

   task automatic test_ack_delay();
      ack_auto = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (if_inst !== NOP || if_pc !== 32'h10 || imem_req !== 1'b1) begin
            errors++; $display("FAIL wait%0d got inst=%h pc=%h req=%b exp inst=%h pc=10 req=1", i, if_inst, if_pc, imem_req, NOP); end
         @(negedge clk);
      end
      ack_auto = 1'b1;
      #1;
      checks++; if (if_inst !== 32'hC0DE_0010 || if_pc !== 32'h10) begin
         errors++; $display("FAIL wait_ack got inst=%h pc=%h exp c0de0010 pc=10", if_inst, if_pc); end
      @(negedge clk);
   endtask

   task automatic test_stall();
      stall = 1'b1;
      #1;
      checks++; if (if_inst !== 32'hC0DE_0014 || if_pc !== 32'h14) begin
         errors++; $display("FAIL stall_ack got inst=%h pc=%h exp c0de0014 pc=14", if_inst, if_pc); end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (if_inst !== 32'hC0DE_0014 || if_pc !== 32'h14 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d got inst=%h pc=%h req=%b exp c0de0014 pc=14 req=0", i, if_inst, if_pc, imem_req); end
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      checks++; if (if_inst !== 32'hC0DE_0014 || imem_req !== 1'b0) begin
         errors++; $display("FAIL stall_rel got inst=%h req=%b exp c0de0014 req=0", if_inst, imem_req); end
      @(negedge clk);
      #1;
      checks++; if (if_pc !== 32'h18 || imem_req !== 1'b1 || if_inst !== 32'hC0DE_0018) begin
         errors++; $display("FAIL stall_next got pc=%h req=%b inst=%h exp pc=18 req=1 c0de0018", if_pc, imem_req, if_inst); end
      @(negedge clk);
   endtask

   task automatic test_redirect_discard();
      // pc is 0x1C here with a request outstanding.
      ack_auto = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      checks++; if (if_inst !== NOP || imem_req !== 1'b1) begin
         errors++; $display("FAIL rd_cyc got inst=%h req=%b exp %h req=1", if_inst, imem_req, NOP); end
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (if_pc !== 32'h100 || imem_req !== 1'b0 || if_inst !== NOP) begin
         errors++; $display("FAIL rd_discard got pc=%h req=%b inst=%h exp pc=100 req=0 %h", if_pc, imem_req, if_inst, NOP); end
      @(negedge clk);
      ack_force = 1'b1;
      #1;
      checks++; if (if_inst !== NOP || imem_req !== 1'b0) begin
         errors++; $display("FAIL rd_late_ack got inst=%h req=%b exp %h req=0", if_inst, imem_req, NOP); end
      @(negedge clk);
      ack_force = 1'b0; ack_auto = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_inst !== 32'hC0DE_0100) begin
         errors++; $display("FAIL rd_refetch got req=%b addr=%h inst=%h exp req=1 addr=100 c0de0100", imem_req, imem_addr, if_inst); end
      @(negedge clk);
   endtask

   task automatic test_misaligned();
      redirect = 1'b1; redirect_pc = 32'h102;
      #1;
      checks++; if (if_inst !== NOP) begin errors++; $display("FAIL mis_drop got %h exp %h", if_inst, NOP); end
      @(negedge clk);
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (if_exc_addr !== 1'b1 || if_pc !== 32'h102 || if_inst !== NOP || imem_req !== 1'b0) begin
            errors++; $display("FAIL mis_park%0d got exc=%b pc=%h inst=%h req=%b exp exc=1 pc=102 inst=%h req=0", i, if_exc_addr, if_pc, if_inst, imem_req, NOP); end
         @(negedge clk);
      end
      checks++; if (if_pc_add4 !== 32'h106) begin errors++; $display("FAIL mis_add4 got %h exp 106", if_pc_add4); end
      redirect = 1'b1; redirect_pc = 32'h200;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_exc_addr !== 1'b0 || if_inst !== 32'hC0DE_0200) begin
         errors++; $display("FAIL mis_exit got req=%b addr=%h exc=%b inst=%h exp req=1 addr=200 exc=0 c0de0200", imem_req, imem_addr, if_exc_addr, if_inst); end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_add4 !== 32'h0 || if_inst !== 32'hC0DE_FFFC) begin
         errors++; $display("FAIL wrap_top got pc=%h add4=%h inst=%h exp fffffffc/0/c0defffc", if_pc, if_pc_add4, if_inst); end
      @(negedge clk);
      #1;
      checks++; if (if_pc !== 32'h0 || if_pc_add4 !== 32'h4) begin
         errors++; $display("FAIL wrap_next got pc=%h add4=%h exp 0/4", if_pc, if_pc_add4); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      // pc is 4 here; leave the request unacknowledged, then reset mid-cycle.
      ack_auto = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || if_pc !== 32'h4) begin
         errors++; $display("FAIL rm_pending got req=%b pc=%h exp req=1 pc=4", imem_req, if_pc); end
      #1 rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || if_pc !== 32'h0 || if_pc_add4 !== 32'h4 || if_inst !== NOP || if_exc_addr !== 1'b0) begin
         errors++; $display("FAIL rm_async got req=%b pc=%h add4=%h inst=%h exc=%b exp 0/0/4/%h/0", imem_req, if_pc, if_pc_add4, if_inst, if_exc_addr, NOP); end
      ack_force = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0 || if_inst !== NOP) begin
         errors++; $display("FAIL rm_boot got req=%b inst=%h exp req=0 %h", imem_req, if_inst, NOP); end
      @(negedge clk);
      ack_force = 1'b0; ack_auto = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_inst !== 32'hC0DE_0000) begin
         errors++; $display("FAIL rm_first got req=%b addr=%h inst=%h exp req=1 addr=0 c0de0000", imem_req, imem_addr, if_inst); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_ack_delay();
      test_stall();
      test_redirect_discard();
      test_misaligned();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
